// File: rtl/prog_loader.sv
// prog_loader: host-side program loader for the 9-bit single-cycle core.
// Receives a byte stream (header N, then N lo/hi byte pairs) and writes
// 9-bit words into the instruction memory. The core is held in reset while
// loading, then released. The loader waits for Done and reports a
// saturating run-cycle count.
//
// Ports:
//   Clk, Reset        clock (rising edge), async active-high reset
//   InDat/InValid     stream byte and its valid flag
//   InReady           loader accepts a byte this cycle (state decode only)
//   ImWen/ImAddr/ImDat  registered instruction memory write port
//   CoreReset         holds the core in reset when high
//   Done              core completion flag
//   RunDone           run finished, Cycles valid
//   Err               sticky stream format error
//   Cycles            core run length in cycles
//
// state | meaning
// ------+-------------------------------------------------------------
// HDR   | waiting for header byte (word count, 0 = 2^AW)
// LO    | waiting for low byte of the current word
// HI    | waiting for high byte; commits the write
// RUN   | core running; first cycle still holds core in reset
// FIN   | run complete, Cycles valid; a new header restarts loading
// ERR   | bad high byte seen; only Reset leaves
module prog_loader #(
    parameter int AW = 6,
    parameter int IW = 9,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [7:0]    InDat,
    input  logic          InValid,
    output logic          InReady,
    output logic          ImWen,
    output logic [AW-1:0] ImAddr,
    output logic [IW-1:0] ImDat,
    output logic          CoreReset,
    input  logic          Done,
    output logic          RunDone,
    output logic          Err,
    output logic [CW-1:0] Cycles
);

    // Remaining-word counter must hold both 2^AW and any 8-bit header.
    localparam int RW = (AW + 1 > 8) ? AW + 1 : 8;
    localparam logic [CW-1:0] CYC_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {
        HDR = 3'd0,
        LO  = 3'd1,
        HI  = 3'd2,
        RUN = 3'd3,
        FIN = 3'd4,
        ERR = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] rem_cnt;
    logic [AW-1:0] word_idx;
    logic [7:0]    lo_byte;
    logic          run_first;
    logic          accept;
    logic          hi_bad;
    logic          last_word;

    assign accept    = InValid & InReady;
    assign hi_bad    = (InDat[7:1] != 7'd0);
    assign last_word = (rem_cnt == RW'(1));

    always_comb begin
        state_nxt = state;
        InReady   = 1'b0;
        CoreReset = 1'b1;
        RunDone   = 1'b0;
        Err       = 1'b0;
        case (state)
            HDR: begin
                InReady = 1'b1;
                if (accept) state_nxt = LO;
            end
            LO: begin
                InReady = 1'b1;
                if (accept) state_nxt = HI;
            end
            HI: begin
                InReady = 1'b1;
                if (accept) begin
                    if (hi_bad)         state_nxt = ERR;
                    else if (last_word) state_nxt = RUN;
                    else                state_nxt = LO;
                end
            end
            RUN: begin
                // The final write is still in flight during the first cycle.
                CoreReset = run_first;
                if (!run_first && Done) state_nxt = FIN;
            end
            FIN: begin
                InReady = 1'b1;
                RunDone = 1'b1;
                if (accept) state_nxt = LO;
            end
            ERR: begin
                Err = 1'b1;
            end
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= HDR;
            rem_cnt   <= '0;
            word_idx  <= '0;
            lo_byte   <= '0;
            run_first <= 1'b0;
            ImWen     <= 1'b0;
            ImAddr    <= '0;
            ImDat     <= '0;
            Cycles    <= '0;
        end else begin
            state <= state_nxt;
            ImWen <= 1'b0;
            case (state)
                HDR, FIN: begin
                    if (accept) begin
                        rem_cnt  <= (InDat == 8'd0) ? (RW'(1) << AW) : RW'(InDat);
                        word_idx <= '0;
                    end
                end
                LO: begin
                    if (accept) lo_byte <= InDat;
                end
                HI: begin
                    if (accept && !hi_bad) begin
                        ImWen    <= 1'b1;
                        ImAddr   <= word_idx;
                        ImDat    <= IW'({InDat[0], lo_byte});
                        word_idx <= word_idx + 1'b1;
                        rem_cnt  <= rem_cnt - 1'b1;
                        if (last_word) begin
                            Cycles    <= '0;
                            run_first <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (run_first) begin
                        run_first <= 1'b0;
                    end else if (!Done && (Cycles != CYC_MAX)) begin
                        Cycles <= Cycles + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    localparam int AW = 6;
    localparam int IW = 9;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [7:0]    InDat;
    logic          InValid;
    logic          InReady;
    logic          ImWen;
    logic [AW-1:0] ImAddr;
    logic [IW-1:0] ImDat;
    logic          CoreReset;
    logic          Done;
    logic          RunDone;
    logic          Err;
    logic [CW-1:0] Cycles;

    prog_loader #(.AW(AW), .IW(IW), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .InDat(InDat), .InValid(InValid),
        .InReady(InReady), .ImWen(ImWen), .ImAddr(ImAddr), .ImDat(ImDat),
        .CoreReset(CoreReset), .Done(Done), .RunDone(RunDone), .Err(Err),
        .Cycles(Cycles)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]    lo;
        logic [7:0]    hi;
        logic [AW-1:0] exp_addr;
        logic [IW-1:0] exp_dat;
    } vec_t;

    vec_t v[7];

    int  n_vec = 0;
    int  n_miss = 0;
    int  spurious = 0;
    time last_hi_time = 0;
    logic [AW-1:0] addr_q[$];
    logic [IW-1:0] dat_q[$];

    // Every write pulse must sit in the cycle right after a high-byte accept.
    always @(negedge Clk) begin
        if (ImWen === 1'b1) begin
            addr_q.push_back(ImAddr);
            dat_q.push_back(ImDat);
            if (($time - last_hi_time) != 5) spurious++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_log();
        addr_q.delete();
        dat_q.delete();
    endtask

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit is_hi, input int gap);
        int t;
        InValid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge Clk);
            #1;
        end
        InDat   = b;
        InValid = 1'b1;
        t = 0;
        while (InReady !== 1'b1 && t < 100) begin
            @(posedge Clk);
            #1;
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: InReady stayed %b, expected 1", InReady);
            InValid = 1'b0;
            return;
        end
        @(posedge Clk);
        if (is_hi) last_hi_time = $time;
        #1;
        InValid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi, input int g1, input int g2);
        send_byte(lo, 1'b0, g1);
        send_byte(hi, 1'b1, g2);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic compare_writes(input string name, input int first, input int cnt);
        check({name, "_count"}, addr_q.size(), cnt);
        for (int i = 0; i < cnt && i < addr_q.size(); i++) begin
            check({name, "_addr"}, addr_q[i], v[first+i].exp_addr);
            check({name, "_dat"}, dat_q[i], v[first+i].exp_dat);
        end
    endtask

    initial begin
        #200000;
        n_vec++;
        n_miss++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        v[0] = '{8'hA5, 8'h01, 6'd0, 9'h1A5};
        v[1] = '{8'h42, 8'h00, 6'd1, 9'h042};
        v[2] = '{8'h00, 8'h01, 6'd2, 9'h100};
        v[3] = '{8'h11, 8'h00, 6'd0, 9'h011};
        v[4] = '{8'hFF, 8'h01, 6'd1, 9'h1FF};
        v[5] = '{8'h80, 8'h00, 6'd2, 9'h080};
        v[6] = '{8'h3C, 8'h01, 6'd3, 9'h13C};

        Reset = 1'b1;
        InDat = 8'h00;
        InValid = 1'b0;
        Done = 1'b0;
        #2;
        check("rst_in_ready", InReady, 1);
        check("rst_wen", ImWen, 0);
        check("rst_addr", ImAddr, 0);
        check("rst_dat", ImDat, 0);
        check("rst_core_reset", CoreReset, 1);
        check("rst_run_done", RunDone, 0);
        check("rst_err", Err, 0);
        check("rst_cycles", Cycles, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // N=3 gap-free load followed by a 10-cycle run
        clear_log();
        send_byte(8'd3, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_word(v[i].lo, v[i].hi, 0, 0);
        check("run1_in_ready", InReady, 0);
        check("run1_last_wen", ImWen, 1);
        check("run1_first_core_reset", CoreReset, 1);
        @(posedge Clk);
        #1;
        check("run1_core_reset_fall", CoreReset, 0);
        check("run1_wen_off", ImWen, 0);
        repeat (10) @(posedge Clk);
        #1;
        check("run1_cycles_pre_done", Cycles, 10);
        Done = 1'b1;
        @(posedge Clk);
        #1;
        Done = 1'b0;
        check("fin1_run_done", RunDone, 1);
        check("fin1_core_reset", CoreReset, 1);
        check("fin1_cycles", Cycles, 10);
        check("fin1_in_ready", InReady, 1);
        check("fin1_addr_hold", ImAddr, 2);
        check("fin1_dat_hold", ImDat, 9'h100);
        compare_writes("n3", 0, 3);

        // N=4 from FIN with random InValid gaps; Done in first RUN cycle ignored
        clear_log();
        send_byte(8'd4, 1'b0, $urandom_range(0, 5));
        check("hdr_clears_run_done", RunDone, 0);
        for (int i = 3; i < 7; i++)
            send_word(v[i].lo, v[i].hi, $urandom_range(0, 5), $urandom_range(0, 5));
        Done = 1'b1;
        @(posedge Clk);
        #1;
        check("early_done_ignored", RunDone, 0);
        check("early_done_core_reset", CoreReset, 0);
        @(posedge Clk);
        #1;
        Done = 1'b0;
        check("fin2_run_done", RunDone, 1);
        check("fin2_cycles", Cycles, 0);
        compare_writes("n4_gaps", 3, 4);
        check("n4_no_spurious_wen", spurious, 0);

        // Header 0: 64 words, value = index
        clear_log();
        send_byte(8'h00, 1'b0, 0);
        for (int i = 0; i < 64; i++) send_word(8'(i), 8'h00, 0, 0);
        check("n64_run_in_ready", InReady, 0);
        repeat (5) @(posedge Clk);
        #1;
        check("n64_count", addr_q.size(), 64);
        for (int i = 0; i < 64 && i < addr_q.size(); i++) begin
            check("n64_addr", addr_q[i], i);
            check("n64_dat", dat_q[i], i);
        end
        check("n64_cycles", Cycles, 4);
        Done = 1'b1;
        @(posedge Clk);
        #1;
        Done = 1'b0;
        check("n64_fin", RunDone, 1);

        // Reset after the LO byte of word 2, then N=1 word 0x0FF
        clear_log();
        send_byte(8'd3, 1'b0, 0);
        send_word(8'h01, 8'h00, 0, 0);
        send_word(8'h02, 8'h00, 0, 0);
        send_byte(8'h03, 1'b0, 0);
        check("midload_cycles_hold", Cycles, 4);
        Reset = 1'b1;
        #1;
        check("async_rst_addr", ImAddr, 0);
        check("async_rst_dat", ImDat, 0);
        check("async_rst_core_reset", CoreReset, 1);
        check("async_rst_in_ready", InReady, 1);
        check("async_rst_cycles", Cycles, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        clear_log();
        send_byte(8'd1, 1'b0, 0);
        check("reload_cycles_zero", Cycles, 0);
        send_word(8'hFF, 8'h00, 0, 0);
        @(posedge Clk);
        #1;
        check("reload_count", addr_q.size(), 1);
        if (addr_q.size() > 0) begin
            check("reload_addr", addr_q[0], 0);
            check("reload_dat", dat_q[0], 9'h0FF);
        end

        // Bad high byte on word 1 of N=2
        pulse_reset();
        clear_log();
        send_byte(8'd2, 1'b0, 0);
        send_word(8'h34, 8'h01, 0, 0);
        send_word(8'h55, 8'h03, 0, 0);
        check("err_flag", Err, 1);
        check("err_in_ready", InReady, 0);
        check("err_core_reset", CoreReset, 1);
        InDat = 8'h01;
        InValid = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("err_sticky", Err, 1);
        check("err_in_ready_hold", InReady, 0);
        check("err_core_reset_hold", CoreReset, 1);
        check("err_write_count", addr_q.size(), 1);
        if (addr_q.size() > 0) begin
            check("err_addr0", addr_q[0], 0);
            check("err_dat0", dat_q[0], 9'h134);
        end
        pulse_reset();
        check("err_cleared", Err, 0);
        check("final_no_spurious_wen", spurious, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Host-side program loader for the 9-bit single-cycle core. It accepts a byte stream over a valid/ready handshake and writes 9-bit machine-code words into the instruction memory write port. It holds the core in reset during loading, then releases it and waits for the core's `Done`. It reports a saturating run-cycle count, and it is the writer end of the instruction-fetch path that the core reads.

## Interface
Parameters:
- `AW`, 6: instruction address width; matches the 6-bit PC.
- `IW`, 9: machine-code width.
- `CW`, 16: cycle-counter width.

Ports. One clock; reset is asynchronous and active-high.
- `Clk` input 1: system clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `InDat` input 8: stream byte.
- `InValid` input 1: `InDat` is valid.
- `InReady` output 1: loader accepts a byte this cycle.
- `ImWen` output 1: instruction memory write enable, one-cycle pulse.
- `ImAddr` output AW: instruction memory write address.
- `ImDat` output IW: instruction memory write data.
- `CoreReset` output 1: drives the core's `Reset`; high means the core is held.
- `Done` input 1: core completion flag.
- `RunDone` output 1: run finished; `Cycles` is valid.
- `Err` output 1: stream format error; sticky.
- `Cycles` output CW: core run length in cycles.

## Operation
- A byte is accepted on a rising edge where `InValid & InReady`.
- A byte not accepted must be held by the sender.
- Stream format:
  - Header byte N gives the word count; N=0 means 2^AW (64) words.
  - Then N pairs, each a low byte then a high byte.
  - The word is `{hi[0], lo}`.
  - `hi[7:1]` must be 0.
- States:
  - HDR: `InReady`=1. Accept the header, load the remaining-count, clear the word index, go to LO.
  - LO: `InReady`=1. Accept and latch the low byte, go to HI.
  - HI: `InReady`=1.
    - Accept high byte with `hi[7:1]`≠0: go to ERR; no write occurs.
    - Otherwise, register a write for the current index and increment the index.
    - If that was the last word, go to RUN; else go to LO.
  - RUN: `InReady`=0.
    - Cycle counter clears on entry.
    - `Done` sampled high while `CoreReset`=0: go to FIN.
  - FIN: `RunDone`=1, `CoreReset`=1, `InReady`=1.
    - Accepting a header clears `RunDone` and behaves as in HDR, going to LO.
    - `Cycles` holds its value until the next RUN entry.
  - ERR: `Err`=1, `InReady`=0, `CoreReset`=1. Only `Reset` exits.
- `CoreReset`:
  - 1 in HDR, LO, HI, FIN and ERR.
  - 1 in the first RUN cycle, while the final write completes.
  - 0 from the second RUN cycle on.
- `Cycles` increments on each edge in RUN with `CoreReset`=0 and `Done`=0. It saturates at 2^CW−1 and never wraps.
- The word index is AW bits; the N=64 load ends at index 63 without an extra wrap write.
- `Done` outside RUN, or during the first RUN cycle, is ignored.
- Instruction memory contents are never cleared by this block.

## Timing
- Reset values:
  - State HDR.
  - `InReady`=1, `ImWen`=0, `ImAddr`=0, `ImDat`=0.
  - `CoreReset`=1, `RunDone`=0, `Err`=0, `Cycles`=0.
- `InReady` is a combinational decode of the state only; it has no path from `InValid`.
- Write latency:
  - `ImWen`, `ImAddr` and `ImDat` are registered.
  - The pulse occurs in the cycle after the high byte is accepted.
  - `ImAddr`/`ImDat` hold until the next write.
- Back-to-back throughput is one word per 2 accepted bytes; gaps in `InValid` stall without side effects.
- `CoreReset` falls exactly one cycle after the final `ImWen` cycle, i.e. at the second RUN cycle.
- Done latency:
  - `Done` high sampled at edge k goes to FIN.
  - `RunDone` and `CoreReset` are high in the cycle after edge k.
  - `Cycles` does not count edge k.
- `Reset` asserted mid-load or mid-run returns all outputs to reset values immediately (asynchronous). The partial load is abandoned and the next byte is treated as a header.

## Test plan
- Load N=3 with words 0x1A5, 0x042, 0x100:
  - Required: `ImWen` pulses at addr 0, 1, 2 with those data.
  - Required: `CoreReset` falls one cycle after the third pulse.
- Header 0x00 with 64 words of value = index:
  - Required: 64 writes at addr 0..63 and no 65th write.
  - Required: then RUN.
- High byte 0x03 on word 1 of N=2:
  - Required: addr 0 is written; no write for word 1.
  - Required: `Err`=1, `InReady`=0, `CoreReset`=1, held until `Reset`.
- After load, `Done`=0 for 10 core cycles, then `Done`=1:
  - Required: `Cycles`=10 and `RunDone`=1 one cycle later, `CoreReset`=1.
  - Required: a new header clears `RunDone` and restarts the load.
- Random `InValid` gaps (0–5 idle cycles) during N=4 load:
  - Required: data and addresses are identical to the gap-free case.
  - Required: no `ImWen` during gaps.
- `Reset` pulse after the LO byte of word 2; then stream N=1 word 0x0FF:
  - Required: the single write is at addr 0 with data 0x0FF.
  - Required: `Cycles` is 0 before RUN.
